intersection_controller: RTL and testbench

Phase sequencer for the four-way intersection. It times green and yellow intervals and drives the vehicle signal heads. It latches left-turn demand from the detectors and skips protected-left phases that have no demand. Its registered `state1` output is the phase code consumed directly by `pedestrian_crossing`.

---
 rtl/traffic_pkg.sv | 81 ++++++++
 rtl/phase_timer.sv | 33 +++
 rtl/intersection_controller.sv | 154 +++++++++++++++
 tb/tb_intersection_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection controller and the
// pedestrian crossing. It holds the 16 phase codes, the signal-head
// encodings and the green ring order, plus small helpers that classify
// phases and test left-turn demand.
package traffic_pkg;

  typedef enum logic [4:0] {
    N_S     = 5'b00000, E_W     = 5'b00001, N_S_Y   = 5'b00010, E_W_Y   = 5'b00011,
    N_NL    = 5'b00100, N_NL_Y  = 5'b00101, S_SL    = 5'b00110, S_SL_Y  = 5'b00111,
    W_WL    = 5'b01000, W_WL_Y  = 5'b01001, E_EL    = 5'b01010, E_EL_Y  = 5'b01011,
    SL_NL   = 5'b01100, SL_NL_Y = 5'b01101, EL_WL   = 5'b01110, EL_WL_Y = 5'b01111
  } phase_e;

  typedef enum logic [1:0] {
    RED = 2'b00,
    GRN = 2'b01,
    YEL = 2'b10
  } light_e;

  // Latched left-turn demand, one bit per approach.
  typedef struct packed {
    logic nl;
    logic sl;
    logic el;
    logic wl;
  } demand_t;

  localparam int unsigned RING_LEN = 8;
  localparam phase_e RING [RING_LEN] = '{N_S, E_W, N_NL, S_SL, W_WL, E_EL, SL_NL, EL_WL};

  function automatic logic is_yellow(phase_e p);
    case (p)
      N_S_Y, E_W_Y, N_NL_Y, S_SL_Y, W_WL_Y, E_EL_Y, SL_NL_Y, EL_WL_Y: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_green(phase_e p);
    case (p)
      N_S, E_W, N_NL, S_SL, W_WL, E_EL, SL_NL, EL_WL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Green phase that a yellow belongs to. Only meaningful for yellow codes.
  function automatic phase_e green_of(phase_e p);
    case (p)
      N_S, N_S_Y: return N_S;
      E_W, E_W_Y: return E_W;
      default:    return phase_e'({p[4:1], 1'b0});
    endcase
  endfunction

  function automatic logic [2:0] ring_index(phase_e g);
    case (g)
      E_W:     return 3'd1;
      N_NL:    return 3'd2;
      S_SL:    return 3'd3;
      W_WL:    return 3'd4;
      E_EL:    return 3'd5;
      SL_NL:   return 3'd6;
      EL_WL:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Whether green phase g may be entered given the latched demand.
  function automatic logic qualifies(phase_e g, demand_t d);
    case (g)
      N_S, E_W: return 1'b1;
      N_NL:     return d.nl & ~d.sl;
      S_SL:     return d.sl & ~d.nl;
      W_WL:     return d.wl & ~d.el;
      E_EL:     return d.el & ~d.wl;
      SL_NL:    return d.sl & d.nl;
      EL_WL:    return d.el & d.wl;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter timing one phase dwell.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (count = RST_DUR-1)
//   load  in   load dur-1 on this edge instead of decrementing
//   dur   in   dwell of the next phase in cycles
//   done  out  count has reached zero (last cycle of the phase)
module phase_timer #(
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_DUR = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_DUR - 1'b1;
    end else if (load) begin
      count <= dur - 1'b1;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/intersection_controller.sv
// intersection_controller: phase sequencer for the four-way intersection.
// Times green and yellow dwells, latches left-turn demand and skips
// protected-left phases without demand.
// Ports:
//   CLK                     in   system clock, rising edge
//   rst                     in   asynchronous active-high reset
//   car_nl/sl/el/wl         in   left-turn lane detectors (level)
//   state1[4:0]             out  registered phase code
//   phase_start             out  high in the first cycle of each phase
//   lt_n/s/e/w[1:0]         out  through heads (00 red, 01 green, 10 yellow)
//   ll_n/s/e/w[1:0]         out  left-turn arrows, same encoding
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned      CNT_W      = 16,
  parameter logic [CNT_W-1:0] GREEN_CYC  = 16'd400,
  parameter logic [CNT_W-1:0] YELLOW_CYC = 16'd100
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       car_nl,
  input  logic       car_sl,
  input  logic       car_el,
  input  logic       car_wl,
  output logic [4:0] state1,
  output logic       phase_start,
  output logic [1:0] lt_n,
  output logic [1:0] lt_s,
  output logic [1:0] lt_e,
  output logic [1:0] lt_w,
  output logic [1:0] ll_n,
  output logic [1:0] ll_s,
  output logic [1:0] ll_e,
  output logic [1:0] ll_w
);

  phase_e           state;
  phase_e           state_next;
  phase_e           next_green;
  demand_t          dem;
  demand_t          car;
  demand_t          clr;
  logic             done;
  logic [CNT_W-1:0] dur;
  light_e           col;

  assign car = '{nl: car_nl, sl: car_sl, el: car_el, wl: car_wl};

  assign dur = is_green(state_next) ? GREEN_CYC : YELLOW_CYC;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_DUR (GREEN_CYC)
  ) u_timer (
    .clk  (CLK),
    .rst  (rst),
    .load (done),
    .dur  (dur),
    .done (done)
  );

  // State, phase_start and demand latches. A detector sample overrides a
  // clear landing on the same edge.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= N_S;
      phase_start <= 1'b1;
      dem         <= '0;
    end else begin
      state       <= state_next;
      phase_start <= done;
      dem         <= demand_t'((dem & ~clr) | car);
    end
  end

  // Walk the ring after the current green; n_s/e_w always qualify, so the
  // search always lands somewhere (wrapping to n_s after e_w at worst).
  always_comb begin
    logic [2:0] cur;
    logic [2:0] idx;
    logic       found;
    next_green = N_S;
    found      = 1'b0;
    cur        = ring_index(green_of(state));
    for (int unsigned k = 1; k < RING_LEN; k++) begin
      idx = cur + k[2:0];
      if (!found && qualifies(RING[idx], dem)) begin
        next_green = RING[idx];
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (done) begin
      case (state)
        N_S:   state_next = N_S_Y;
        E_W:   state_next = E_W_Y;
        N_NL:  state_next = N_NL_Y;
        S_SL:  state_next = S_SL_Y;
        W_WL:  state_next = W_WL_Y;
        E_EL:  state_next = E_EL_Y;
        SL_NL: state_next = SL_NL_Y;
        EL_WL: state_next = EL_WL_Y;
        N_S_Y, E_W_Y, N_NL_Y, S_SL_Y, W_WL_Y, E_EL_Y, SL_NL_Y, EL_WL_Y:
               state_next = next_green;
        default: state_next = N_S_Y;
      endcase
    end
  end

  // Demand clears on the last green cycle of a phase showing that arrow.
  always_comb begin
    clr = '0;
    if (done) begin
      case (state)
        N_NL:  clr.nl = 1'b1;
        S_SL:  clr.sl = 1'b1;
        W_WL:  clr.wl = 1'b1;
        E_EL:  clr.el = 1'b1;
        SL_NL: begin clr.sl = 1'b1; clr.nl = 1'b1; end
        EL_WL: begin clr.el = 1'b1; clr.wl = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    col  = is_yellow(state) ? YEL : GRN;
    lt_n = RED;
    lt_s = RED;
    lt_e = RED;
    lt_w = RED;
    ll_n = RED;
    ll_s = RED;
    ll_e = RED;
    ll_w = RED;
    case (state)
      N_S,   N_S_Y:   begin lt_n = col; lt_s = col; end
      E_W,   E_W_Y:   begin lt_e = col; lt_w = col; end
      N_NL,  N_NL_Y:  begin lt_n = col; ll_n = col; end
      S_SL,  S_SL_Y:  begin lt_s = col; ll_s = col; end
      W_WL,  W_WL_Y:  begin lt_w = col; ll_w = col; end
      E_EL,  E_EL_Y:  begin lt_e = col; ll_e = col; end
      SL_NL, SL_NL_Y: begin ll_s = col; ll_n = col; end
      EL_WL, EL_WL_Y: begin ll_e = col; ll_w = col; end
      default: ;
    endcase
  end

  assign state1 = state;

endmodule

// File: tb/tb_intersection_controller.sv
module tb_intersection_controller;
  import traffic_pkg::*;

  localparam int unsigned G = 4;
  localparam int unsigned Y = 2;

  // Ring-position tables taken from the phase list: green/yellow codes,
  // demand needed / forbidden, arrows served, and heads lit
  // (head bit h: 0 lt_n,1 lt_s,2 lt_e,3 lt_w,4 ll_n,5 ll_s,6 ll_e,7 ll_w).
  // Demand bits: 0 nl, 1 sl, 2 el, 3 wl.
  localparam logic [4:0] GCODE [8] = '{5'd0, 5'd1, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14};
  localparam logic [4:0] YCODE [8] = '{5'd2, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15};
  localparam logic [3:0] NEED  [8] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h8, 4'h4, 4'h3, 4'hC};
  localparam logic [3:0] FORBID[8] = '{4'h0, 4'h0, 4'h2, 4'h1, 4'h4, 4'h8, 4'h0, 4'h0};
  localparam logic [3:0] ARROW [8] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h8, 4'h4, 4'h3, 4'hC};
  localparam logic [7:0] HEADS [8] = '{8'h03, 8'h0C, 8'h11, 8'h22, 8'h88, 8'h44, 8'h30, 8'hC0};

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] car = '0;
  logic [4:0] state1;
  logic       phase_start;
  logic [1:0] lt_n, lt_s, lt_e, lt_w, ll_n, ll_s, ll_e, ll_w;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: ring position, yellow flag, cycles elapsed in phase.
  int unsigned m_g;
  bit          m_y;
  int unsigned m_e;
  logic [3:0]  m_dem;
  bit          m_ps;

  intersection_controller #(
    .CNT_W      (16),
    .GREEN_CYC  (16'(G)),
    .YELLOW_CYC (16'(Y))
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .car_nl      (car[0]),
    .car_sl      (car[1]),
    .car_el      (car[2]),
    .car_wl      (car[3]),
    .state1      (state1),
    .phase_start (phase_start),
    .lt_n        (lt_n),
    .lt_s        (lt_s),
    .lt_e        (lt_e),
    .lt_w        (lt_w),
    .ll_n        (ll_n),
    .ll_s        (ll_s),
    .ll_e        (ll_e),
    .ll_w        (ll_w)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] heads_now();
    return {lt_n, lt_s, lt_e, lt_w, ll_n, ll_s, ll_e, ll_w};
  endfunction

  function automatic logic [15:0] heads_exp();
    logic [15:0] e;
    logic [1:0]  c;
    e = '0;
    c = m_y ? 2'b10 : 2'b01;
    for (int h = 0; h < 8; h++) begin
      e = {e[13:0], (HEADS[m_g][h] ? c : 2'b00)};
    end
    return e;
  endfunction

  task automatic model_reset();
    m_g = 0; m_y = 0; m_e = 0; m_dem = '0; m_ps = 1;
  endtask

  task automatic model_edge(input logic [3:0] c);
    int unsigned dur_now;
    int unsigned ng;
    bit          found;
    logic [3:0]  clr;
    int unsigned cand;
    dur_now = m_y ? Y : G;
    clr = '0;
    if (m_e == dur_now - 1) begin
      if (m_y) begin
        ng = 0;
        found = 0;
        for (int k = 1; k < 8; k++) begin
          cand = (m_g + k) % 8;
          if (!found && ((m_dem & NEED[cand]) == NEED[cand]) && ((m_dem & FORBID[cand]) == 4'h0)) begin
            ng = cand;
            found = 1;
          end
        end
        m_g = ng;
        m_y = 0;
      end else begin
        clr = ARROW[m_g];
        m_y = 1;
      end
      m_e = 0;
      m_ps = 1;
    end else begin
      m_e++;
      m_ps = 0;
    end
    m_dem = (m_dem & ~clr) | c;
  endtask

  task automatic check_outputs();
    check("state1", 32'(state1), 32'(m_y ? YCODE[m_g] : GCODE[m_g]));
    check("phase_start", 32'(phase_start), 32'(m_ps));
    check("heads", 32'(heads_now()), 32'(heads_exp()));
  endtask

  task automatic step(input logic [3:0] c);
    car = c;
    @(posedge CLK);
    model_edge(c);
    #1;
    check_outputs();
  endtask

  // Reset asserted between clock edges; its effect must be visible
  // before any edge arrives.
  task automatic mid_reset();
    #($urandom_range(1, 3));
    rst = 1'b1;
    car = '0;
    #1;
    model_reset();
    check("rst_state1", 32'(state1), 32'd0);
    check("rst_heads", 32'(heads_now()), 32'h5000);
    check_outputs();
    @(posedge CLK);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned guard;
    model_reset();
    #2;
    mid_reset();

    // Force an unused code on the last n_s cycle: all red for that cycle,
    // then n_s_y, then e_w exactly as the model continues.
    for (int i = 0; i < int'(G) - 1; i++) step(4'h0);
    force dut.state = phase_e'(5'b10101);
    #1;
    check("unused_state1", 32'(state1), 32'h15);
    check("unused_heads", 32'(heads_now()), 32'h0);
    #1;
    release dut.state;
    for (int i = 0; i < 16; i++) step(4'h0);

    // No demand: plain 12-cycle ring.
    for (int i = 0; i < 24; i++) step(4'h0);

    // Single nl pulse, then el+wl pulse, then nl held for a long stretch.
    step(4'h1);
    for (int i = 0; i < 30; i++) step(4'h0);
    step(4'hC);
    for (int i = 0; i < 30; i++) step(4'h0);
    for (int i = 0; i < 40; i++) step(4'h1);
    for (int i = 0; i < 20; i++) step(4'h0);

    // Reset in cycle 2 of e_w.
    guard = 0;
    while (!(m_g == 1 && !m_y && m_e == 1) && guard < 50) begin
      step(4'h0);
      guard++;
    end
    check("reach_e_w", 32'(guard < 50), 32'd1);
    mid_reset();
    for (int i = 0; i < 8; i++) step(4'h0);

    // Random detector traffic with occasional asynchronous resets.
    for (int i = 0; i < 900; i++) begin
      logic [3:0] c;
      for (int b = 0; b < 4; b++) c[b] = ($urandom_range(0, 5) == 0);
      step(c);
      if ($urandom_range(0, 199) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
